// File: rtl/host_master.sv
// rtl/host_master.sv - burst bus master turning single commands into granted bus beats
//
// Purpose: accepts a read or write burst command (start address, beat count),
// requests the shared bus, issues one beat per granted cycle and returns read
// data one cycle after each read beat. A one-cycle done pulse closes the burst.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_wr, cmd_addr, cmd_cnt (beats-1)
//   wd_valid/wd_ready      write data handshake; wd_data
//   rd_valid, rd_data      read beat return (no backpressure)
//   done                   one-cycle burst completion pulse
//   M0_req, M0_wr          bus request and write strobe
//   M0_address, M0_dout    bus address and write data
//   M0_grant               bus grant for the current cycle
//   M_din                  bus read data, one cycle after a granted read beat

module host_master (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_addr,
    input  logic [3:0]  cmd_cnt,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [31:0] wd_data,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        M0_req,
    output logic        M0_wr,
    output logic [7:0]  M0_address,
    output logic [31:0] M0_dout,
    input  logic        M0_grant,
    input  logic [31:0] M_din
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_XFER  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [7:0]  addr_q, addr_d;
    // Five bits so a 16-beat burst (cmd_cnt = 15) is representable.
    logic [4:0]  beats_q, beats_d;
    logic        rd_pend_q, rd_pend_d;

    logic        active;
    logic        issue;
    logic        last_beat;

    // A beat goes out whenever we own the bus this cycle and, for writes,
    // the data source has a word ready. A write stall is simply "no issue".
    always_comb begin
        active    = (state_q == S_REQ) || (state_q == S_XFER);
        issue     = active && M0_grant && (!wr_q || wd_valid);
        last_beat = issue && (beats_q == 5'd1);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            addr_q    <= 8'h00;
            beats_q   <= 5'd0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            beats_q   <= beats_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        beats_d   = beats_q;
        rd_pend_d = issue && !wr_q;

        if (issue) begin
            addr_d  = addr_q + 8'd1;
            beats_d = beats_q - 5'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    wr_d    = cmd_wr;
                    addr_d  = cmd_addr;
                    beats_d = {1'b0, cmd_cnt} + 5'd1;
                    state_d = S_REQ;
                end
            end
            S_REQ, S_XFER: begin
                if (last_beat) begin
                    // Reads need one more cycle to present the final beat.
                    state_d = wr_q ? S_DONE : S_DRAIN;
                end else if (M0_grant) begin
                    state_d = S_XFER;
                end else begin
                    // Losing grant keeps address and remaining count intact.
                    state_d = S_REQ;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        cmd_ready  = (state_q == S_IDLE);
        M0_req     = active;
        M0_wr      = issue && wr_q;
        wd_ready   = issue && wr_q;
        M0_dout    = (issue && wr_q) ? wd_data : 32'h0;
        M0_address = addr_q;
        rd_valid   = rd_pend_q;
        rd_data    = rd_pend_q ? M_din : 32'h0;
        done       = (state_q == S_DONE);
    end

endmodule
